rst_seq: RTL and testbench



---
 rtl/rst_seq.sv | 198 +++++++++++++++++++
 tb/tb_rst_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// Reset sequencer: synchronises pll_lock, stretches reset after lock, then releases
// N_CH reset domains in order. Optional watchdog re-entry when RST_SEQ_WDT_EN is defined.
module rst_seq #(
   parameter int N_CH        = 2,
   parameter int STRETCH_W   = 6,
   parameter int GAP_CYCLES  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int WDT_W       = 24
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pll_lock,
   input  logic            soft_rst_req,
   input  logic            wdt_kick,
   output logic [N_CH-1:0] rst_out,
   output logic            ready,
   output logic [1:0]      last_cause
);

   localparam int          IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   localparam logic [1:0] CAUSE_POR  = 2'd0;
   localparam logic [1:0] CAUSE_LOCK = 2'd1;
   localparam logic [1:0] CAUSE_SOFT = 2'd2;
`ifdef RST_SEQ_WDT_EN
   localparam logic [1:0] CAUSE_WDT  = 2'd3;
`endif

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STRETCH   = 2'd1,
      RELEASE   = 2'd2,
      DONE      = 2'd3
   } state_t;

   // Initialisers match the reset values so the block also sequences from FPGA configuration.
   state_t                 state_q   = WAIT_LOCK;
   state_t                 state_d;
   logic [SYNC_STAGES-1:0] sync_q    = '0;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [STRETCH_W-1:0]   cnt_q     = '0;
   logic [STRETCH_W-1:0]   cnt_d;
   logic [15:0]            gap_q     = '0;
   logic [15:0]            gap_d;
   logic [IDX_W-1:0]       idx_q     = '0;
   logic [IDX_W-1:0]       idx_d;
   logic [N_CH-1:0]        rst_out_q = '1;
   logic [N_CH-1:0]        rst_out_d;
   logic                   ready_q   = 1'b0;
   logic                   ready_d;
   logic [1:0]             cause_q   = 2'd0;
   logic [1:0]             cause_d;
`ifdef RST_SEQ_WDT_EN
   logic [WDT_W-1:0]       wdt_q     = '0;
   logic [WDT_W-1:0]       wdt_d;
`else
   logic                   unused_wdt;
   assign unused_wdt = wdt_kick & (WDT_W != 0);
`endif

   logic       lock_s;
   logic       reenter;
   logic [1:0] reenter_cause;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d        = {sync_q[SYNC_STAGES-2:0], pll_lock};
      state_d       = state_q;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      idx_d         = idx_q;
      rst_out_d     = rst_out_q;
      ready_d       = ready_q;
      cause_d       = cause_q;
      reenter       = 1'b0;
      reenter_cause = CAUSE_POR;
`ifdef RST_SEQ_WDT_EN
      wdt_d         = '0;
`endif

      // Lock loss outranks a soft request arriving in the same cycle.
      if (state_q != WAIT_LOCK) begin
         if (!lock_s) begin
            reenter       = 1'b1;
            reenter_cause = CAUSE_LOCK;
         end else if (soft_rst_req) begin
            reenter       = 1'b1;
            reenter_cause = CAUSE_SOFT;
         end
      end

      case (state_q)
         WAIT_LOCK: begin
            rst_out_d = '1;
            ready_d   = 1'b0;
            cnt_d     = '0;
            gap_d     = '0;
            idx_d     = '0;
            if (soft_rst_req) cause_d = CAUSE_SOFT;
            if (lock_s)       state_d = STRETCH;
         end
         STRETCH: begin
            if (cnt_q == '1) begin
               if (N_CH == 1) begin
                  rst_out_d = '0;
                  ready_d   = 1'b1;
                  state_d   = DONE;
               end else begin
                  rst_out_d[0] = 1'b0;
                  idx_d        = IDX_W'(1);
                  gap_d        = '0;
                  state_d      = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (gap_q == GAP_LAST) begin
               for (int i = 0; i < N_CH; i++) begin
                  if (i == int'(idx_q)) rst_out_d[i] = 1'b0;
               end
               gap_d = '0;
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_W'(N_CH - 1)) begin
                  ready_d = 1'b1;
                  state_d = DONE;
               end
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         DONE: begin
`ifdef RST_SEQ_WDT_EN
            if (wdt_kick) begin
               wdt_d = '0;
            end else if (wdt_q == '1) begin
               if (!reenter) begin
                  reenter       = 1'b1;
                  reenter_cause = CAUSE_WDT;
               end
            end else begin
               wdt_d = wdt_q + 1'b1;
            end
`endif
         end
         default: state_d = WAIT_LOCK;
      endcase

      if (reenter) begin
         state_d   = WAIT_LOCK;
         rst_out_d = '1;
         ready_d   = 1'b0;
         cnt_d     = '0;
         gap_d     = '0;
         idx_d     = '0;
         cause_d   = reenter_cause;
`ifdef RST_SEQ_WDT_EN
         wdt_d     = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WAIT_LOCK;
         sync_q    <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
         cause_q   <= CAUSE_POR;
`ifdef RST_SEQ_WDT_EN
         wdt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
         cause_q   <= cause_d;
`ifdef RST_SEQ_WDT_EN
         wdt_q     <= wdt_d;
`endif
      end
   end

   assign rst_out    = rst_out_q;
   assign ready      = ready_q;
   assign last_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus pushes expected output events (edge, value),
// a monitor pops one whenever the registered outputs change.
module tb_rst_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_lock = 1'b1;
   logic       soft_rst_req = 1'b0;
   logic       wdt_kick = 1'b0;
   logic [2:0] rst_out;
   logic       ready;
   logic [1:0] last_cause;

   rst_seq #(
      .N_CH(3), .STRETCH_W(4), .GAP_CYCLES(4), .SYNC_STAGES(2), .WDT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
      .wdt_kick(wdt_kick), .rst_out(rst_out), .ready(ready), .last_cause(last_cause)
   );

   always #5 clk = ~clk;

   // cyc == k during the half period after the k-th rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [2:0] ro;
      logic       rdy;
      logic [1:0] cause;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   task automatic expect_ev(input int at, input logic [2:0] ro, input logic rdy, input logic [1:0] c);
      ev_t e;
      e.at = at; e.ro = ro; e.rdy = rdy; e.cause = c;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [2:0] ro, input logic rdy, input logic [1:0] c);
      tests++;
      if (rst_out !== ro || ready !== rdy || last_cause !== c) begin
         fails++;
         $display("FAIL %s cyc=%0d: got ro=%b rdy=%b cause=%0d, want ro=%b rdy=%b cause=%0d",
                  name, cyc, rst_out, ready, last_cause, ro, rdy, c);
      end
   endtask

   // Monitor: every output change must match the next expected event, including its edge.
   initial begin
      logic [2:0] p_ro;
      logic       p_rdy;
      logic [1:0] p_c;
      ev_t        e;
      #1;
      p_ro = rst_out; p_rdy = ready; p_c = last_cause;
      forever begin
         @(negedge clk);
         if ({rst_out, ready, last_cause} !== {p_ro, p_rdy, p_c}) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change cyc=%0d: got ro=%b rdy=%b cause=%0d, none expected",
                        cyc, rst_out, ready, last_cause);
            end else begin
               e = exp_q.pop_front();
               if (cyc != e.at || rst_out !== e.ro || ready !== e.rdy || last_cause !== e.cause) begin
                  fails++;
                  $display("FAIL event: got cyc=%0d ro=%b rdy=%b cause=%0d, want cyc=%0d ro=%b rdy=%b cause=%0d",
                           cyc, rst_out, ready, last_cause, e.at, e.ro, e.rdy, e.cause);
               end
            end
            p_ro = rst_out; p_rdy = ready; p_c = last_cause;
         end
      end
   end

   initial begin
      #1;
      // Power-up from initialisers only, lock sampled high from edge 1.
      check("init_state", 3'b111, 1'b0, 2'd0);
      expect_ev(19, 3'b110, 1'b0, 2'd0);
      expect_ev(23, 3'b100, 1'b0, 2'd0);
      expect_ev(27, 3'b000, 1'b1, 2'd0);

      // rst pulse then normal sequence from lock sampled at edge 32.
      wait_cyc(30); rst = 1'b1;
      expect_ev(31, 3'b111, 1'b0, 2'd0);
      wait_cyc(31); rst = 1'b0;
      check("rst_state", 3'b111, 1'b0, 2'd0);
      expect_ev(50, 3'b110, 1'b0, 2'd0);
      expect_ev(54, 3'b100, 1'b0, 2'd0);
      expect_ev(58, 3'b000, 1'b1, 2'd0);

      // Soft request in DONE; lock still good so STRETCH restarts next edge.
      wait_cyc(60); soft_rst_req = 1'b1;
      expect_ev(61, 3'b111, 1'b0, 2'd2);
      wait_cyc(61); soft_rst_req = 1'b0;
      expect_ev(78, 3'b110, 1'b0, 2'd2);
      expect_ev(82, 3'b100, 1'b0, 2'd2);
      expect_ev(86, 3'b000, 1'b1, 2'd2);

      // Lock loss during RELEASE; re-entry wins over the bit-2 release on the same edge.
      wait_cyc(90); rst = 1'b1;
      expect_ev(91, 3'b111, 1'b0, 2'd0);
      wait_cyc(91); rst = 1'b0;
      expect_ev(110, 3'b110, 1'b0, 2'd0);
      expect_ev(114, 3'b100, 1'b0, 2'd0);
      wait_cyc(115); pll_lock = 1'b0;
      expect_ev(118, 3'b111, 1'b0, 2'd1);
      wait_cyc(120); pll_lock = 1'b1;
      expect_ev(139, 3'b110, 1'b0, 2'd1);
      expect_ev(143, 3'b100, 1'b0, 2'd1);
      expect_ev(147, 3'b000, 1'b1, 2'd1);

      // Soft request in WAIT_LOCK only changes the cause.
      wait_cyc(150); rst = 1'b1; pll_lock = 1'b0;
      expect_ev(151, 3'b111, 1'b0, 2'd0);
      wait_cyc(151); rst = 1'b0;
      wait_cyc(153); soft_rst_req = 1'b1;
      expect_ev(154, 3'b111, 1'b0, 2'd2);
      wait_cyc(154); soft_rst_req = 1'b0;

      // Lock loss and soft request reach the FSM on the same edge in DONE.
      wait_cyc(156); rst = 1'b1; pll_lock = 1'b1;
      expect_ev(157, 3'b111, 1'b0, 2'd0);
      wait_cyc(157); rst = 1'b0;
      expect_ev(176, 3'b110, 1'b0, 2'd0);
      expect_ev(180, 3'b100, 1'b0, 2'd0);
      expect_ev(184, 3'b000, 1'b1, 2'd0);
      wait_cyc(190); pll_lock = 1'b0;
      wait_cyc(192); soft_rst_req = 1'b1;
      expect_ev(193, 3'b111, 1'b0, 2'd1);
      wait_cyc(193); soft_rst_req = 1'b0;
      wait_cyc(196); pll_lock = 1'b1;
      expect_ev(215, 3'b110, 1'b0, 2'd1);

      // rst held 3 cycles in RELEASE with soft request; no early release after.
      wait_cyc(216); rst = 1'b1; soft_rst_req = 1'b1;
      expect_ev(217, 3'b111, 1'b0, 2'd0);
      wait_cyc(218);
      check("rst_hold", 3'b111, 1'b0, 2'd0);
      wait_cyc(219); rst = 1'b0; soft_rst_req = 1'b0;
      expect_ev(238, 3'b110, 1'b0, 2'd0);
      expect_ev(242, 3'b100, 1'b0, 2'd0);
      expect_ev(246, 3'b000, 1'b1, 2'd0);

`ifndef RST_SEQ_WDT_EN
      // Without the watchdog, kicks (or their absence) never disturb DONE.
      wait_cyc(300); wdt_kick = 1'b1;
      wait_cyc(301); wdt_kick = 1'b0;
      wait_cyc(1260);
      check("wdt_off_idle", 3'b000, 1'b1, 2'd0);
`else
      wait_cyc(250);
`endif

      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_events: got %0d still pending, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
